memblock_arbiter: RTL and testbench
===================================

# memblock_arbiter

Sequencer and two-requester arbiter for the single-read/single-write `Memblock` storage used in the simple core. It shares the memory's one read port and one write port between requester A (core datapath) and requester B (loader/debug), one access per cycle with round-robin fairness. It also provides a synchronous clear sequence that zeroes every entry through the normal write port, so the rest of the design never needs `Memblock`'s asynchronous reset.

## Interface

- `WIDTH`, 32, data width; must match the attached `Memblock`.
- `DEPTH`, 32, number of entries; a power of two, at least 2. `AW = $clog2(DEPTH)`.
- `CLEAR_ON_RESET`, 1, when 1 the block enters CLEAR on leaving reset; when 0 it enters RUN.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `clear_start`  in  1  one-cycle pulse that requests a full clear.
- `clear_busy`  out  1  high while in CLEAR.
- `a_req`, `b_req`  in  1  access request, held until granted.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  AW  entry address.
- `a_wdata`, `b_wdata`  in  WIDTH  write data.
- `a_gnt`, `b_gnt`  out  1  combinational grant; the request is accepted this cycle.
- `a_rvalid`, `b_rvalid`  out  1  read data valid for that requester.
- `rdata`  out  WIDTH  shared read data, meaningful only while some `*_rvalid` is high.
- `mem_rd_addr`  out  AW  drives the Memblock read address.
- `mem_wr_addr`  out  AW  drives the Memblock write address.
- `mem_wr_din`  out  WIDTH  drives the Memblock write data.
- `mem_we`  out  1  drives the Memblock write enable.
- `mem_rd_dout`  in  WIDTH  Memblock asynchronous read data.

## Operation

- States: CLEAR and RUN.
- Reset (`rst`=1 at an edge):
  - state becomes CLEAR if `CLEAR_ON_RESET` is 1, otherwise RUN.
  - clear counter = 0; pipeline valid = 0; `last` = B, so A wins the first tie.
  - While `rst` is high, `a_gnt`, `b_gnt`, `a_rvalid`, `b_rvalid` and `mem_we` are 0.
- CLEAR:
  - Each cycle: `mem_we` = 1, `mem_wr_addr` = counter, `mem_wr_din` = 0; counter increments.
  - After writing address DEPTH-1, the counter wraps to 0 and the state goes to RUN.
  - Duration is exactly DEPTH cycles; `clear_busy` = 1 throughout.
  - No grants are issued; `clear_start` is ignored.
- RUN, arbitration (combinational):
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the one that is not `last`.
  - `last` updates to the winner on every grant.
  - With `clear_start` = 1 there is no grant this cycle; next state is CLEAR.
- RUN, access stage (registered, one entry):
  - On a grant, capture requester id, we, addr and wdata; set valid.
  - Next cycle, write op: `mem_we` = 1, `mem_wr_addr`/`mem_wr_din` from the stage.
  - Next cycle, read op: `mem_rd_addr` = stage addr, `rdata` = `mem_rd_dout`, and the owner's `rvalid` = 1 for one cycle.
  - Valid clears when no new grant occurs.
- Idle values:
  - `mem_we` = 0 whenever the stage is empty in RUN.
  - `mem_rd_addr` holds its last value; it has no functional effect.
  - `rdata` = 0 when no `rvalid` is high.
- An access already in the stage when `clear_start` arrives still completes in the first CLEAR cycle's predecessor. That is, it is issued in the same cycle `clear_start` is seen, and CLEAR begins the following cycle.
- Reset mid-CLEAR or mid-access aborts it: the stage is dropped and no `rvalid` pulse is produced.

## Timing

- Grant: same cycle as `req` (combinational).
- Write: takes effect at the edge ending cycle N+1 when granted in cycle N.
- Read: `rvalid`/`rdata` in cycle N+1. Read latency 1, throughput 1 access per cycle.
- Read after write to the same address, granted back-to-back (write in N, read in N+1): the read in N+2 returns the new data.
- Sustained dual requests alternate A, B, A, B; neither requester waits more than 1 cycle.
- CLEAR from `clear_start` in cycle N: `clear_busy` is high in cycles N+1 … N+DEPTH, and the first grant is possible in cycle N+DEPTH+1.

## Test plan

- **Reset clear (CLEAR_ON_RESET=1, DEPTH=32)** → after release of `rst`:
  - `clear_busy` = 1 for 32 cycles, `mem_we` = 1 with addresses 0..31 and data 0.
  - Then a read of address 5 by A returns 0 with `a_rvalid` one cycle after `a_gnt`.
- **Write then read by A** (addr 3, data 0xDEADBEEF, back-to-back) → `mem_we` in cycle N+1; read in cycle N+2 returns 0xDEADBEEF with `a_rvalid`.
- **Contention**: A and B both hold `req` for 6 cycles from reset → grant order A, B, A, B, A, B; each `rvalid` is routed only to its owner.
- **clear_start while B writes addr 7 = 0x55** (same cycle as B's grant):
  - no grant that cycle (B is held);
  - CLEAR runs 32 cycles;
  - B is then granted; a final read of addr 7 returns 0x55.
- **Reset during CLEAR at counter 10** → the next cycle restarts CLEAR at address 0, no grants are issued, and `clear_busy` stays high for 32 further cycles.
- **CLEAR_ON_RESET=0** → a grant is available in the first cycle after reset; `mem_we` stays 0 until the first write.

Source files
------------

// File: rtl/memblock_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memblock_arbiter_if
// Brief    : Requester, control and Memblock-side signals of memblock_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memblock_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             clear_start;
    logic             clear_busy;
    logic             a_req;
    logic             b_req;
    logic             a_we;
    logic             b_we;
    logic [AW-1:0]    a_addr;
    logic [AW-1:0]    b_addr;
    logic [WIDTH-1:0] a_wdata;
    logic [WIDTH-1:0] b_wdata;
    logic             a_gnt;
    logic             b_gnt;
    logic             a_rvalid;
    logic             b_rvalid;
    logic [WIDTH-1:0] rdata;
    logic [AW-1:0]    mem_rd_addr;
    logic [AW-1:0]    mem_wr_addr;
    logic [WIDTH-1:0] mem_wr_din;
    logic             mem_we;
    logic [WIDTH-1:0] mem_rd_dout;

    modport slave (
        input  clear_start, a_req, b_req, a_we, b_we, a_addr, b_addr,
               a_wdata, b_wdata, mem_rd_dout,
        output clear_busy, a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we
    );

    modport master (
        output clear_start, a_req, b_req, a_we, b_we, a_addr, b_addr,
               a_wdata, b_wdata, mem_rd_dout,
        input  clear_busy, a_gnt, b_gnt, a_rvalid, b_rvalid, rdata,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we
    );
endinterface
`default_nettype wire

// File: rtl/memblock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memblock_arbiter
// Brief    : Round-robin two-requester sequencer for Memblock with a
//            synchronous full-clear sequence driven through the write port.
// Revision : 1.0 - initial release
// ============================================================================
module memblock_arbiter #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    memblock_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    clr_cnt;
    logic [AW-1:0]    clr_cnt_next;
    logic             last;
    logic             last_next;
    logic             grant_a;
    logic             grant_b;
    logic             grant_any;

    logic             stg_valid;
    logic             stg_id;
    logic             stg_we;
    logic [AW-1:0]    stg_addr;
    logic [WIDTH-1:0] stg_wdata;
    logic             issue_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
            last    <= ID_B;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
            last    <= last_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        last_next    = last;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        if (!rst) begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt_next = clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        clr_cnt_next = '0;
                        state_next   = ST_RUN;
                    end
                end
                default: begin
                    if (bus.clear_start) begin
                        state_next = ST_CLEAR;
                    end else if (bus.a_req && bus.b_req) begin
                        // Tie goes to whoever did not win last time.
                        grant_a = (last == ID_B);
                        grant_b = (last == ID_A);
                    end else begin
                        grant_a = bus.a_req;
                        grant_b = bus.b_req;
                    end
                    if (grant_a) begin
                        last_next = ID_A;
                    end else if (grant_b) begin
                        last_next = ID_B;
                    end
                end
            endcase
        end
    end

    assign grant_any = grant_a | grant_b;

    // Payload registers need no reset: stg_valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= 1'b0;
        end else begin
            stg_valid <= grant_any;
        end
        if (grant_any) begin
            stg_id    <= grant_b ? ID_B : ID_A;
            stg_we    <= grant_b ? bus.b_we    : bus.a_we;
            stg_addr  <= grant_b ? bus.b_addr  : bus.a_addr;
            stg_wdata <= grant_b ? bus.b_wdata : bus.a_wdata;
        end
    end

    always_comb begin
        bus.mem_we      = 1'b0;
        bus.mem_wr_addr = stg_addr;
        bus.mem_wr_din  = stg_wdata;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                bus.mem_we      = 1'b1;
                bus.mem_wr_addr = clr_cnt;
                bus.mem_wr_din  = '0;
            end else if (stg_valid && stg_we) begin
                bus.mem_we = 1'b1;
            end
        end
    end

    assign issue_rd        = !rst && (state == ST_RUN) && stg_valid && !stg_we;
    assign bus.mem_rd_addr = stg_addr;
    assign bus.a_gnt       = grant_a;
    assign bus.b_gnt       = grant_b;
    assign bus.a_rvalid    = issue_rd && (stg_id == ID_A);
    assign bus.b_rvalid    = issue_rd && (stg_id == ID_B);
    assign bus.rdata       = issue_rd ? bus.mem_rd_dout : '0;
    assign bus.clear_busy  = (state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_memblock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memblock_arbiter
// Brief    : Directed and randomized bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_memblock_arbiter;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic garble = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    memblock_arbiter_if #(.WIDTH(W), .DEPTH(D)) bus ();
    memblock_arbiter_if #(.WIDTH(W), .DEPTH(8)) bus0 ();

    memblock_arbiter #(.WIDTH(W), .DEPTH(D), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    memblock_arbiter #(.WIDTH(W), .DEPTH(8), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    // Memblock stand-in: async read, write on the clock edge.
    logic [W-1:0] mem [D];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_wr_addr] <= bus.mem_wr_din;
        else if (garble) mem[AW'($urandom_range(D - 1))] <= $urandom;
    end
    assign bus.mem_rd_dout  = mem[bus.mem_rd_addr];
    assign bus0.mem_rd_dout = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit            id;   // 1 = B
        bit            we;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } acc_t;

    function automatic acc_t mk(bit id, bit we, logic [AW-1:0] a, logic [W-1:0] d);
        acc_t r;
        r.id = id; r.we = we; r.addr = a; r.data = d;
        return r;
    endfunction

    acc_t         pipe [$];
    logic [W-1:0] refmem [D];
    bit           m_clear = 1'b0;
    int           m_idx   = 0;
    bit           m_last  = 1'b1;

    always @(negedge clk) begin : model
        bit ea, eb, era, erb, ewe;
        logic [W-1:0] erd;
        acc_t acc;
        ea = 0; eb = 0; era = 0; erb = 0; ewe = 0; erd = '0;
        if (rst) begin
            check1("rst_a_gnt", bus.a_gnt, 1'b0);
            check1("rst_b_gnt", bus.b_gnt, 1'b0);
            check1("rst_a_rvalid", bus.a_rvalid, 1'b0);
            check1("rst_b_rvalid", bus.b_rvalid, 1'b0);
            check1("rst_mem_we", bus.mem_we, 1'b0);
            m_clear = 1'b1; m_idx = 0; m_last = 1'b1;
            pipe.delete();
        end else if (m_clear) begin
            check1("clr_busy", bus.clear_busy, 1'b1);
            check1("clr_we", bus.mem_we, 1'b1);
            check("clr_addr", 32'(bus.mem_wr_addr), 32'(m_idx));
            check("clr_din", bus.mem_wr_din, 32'd0);
            check1("clr_a_gnt", bus.a_gnt, 1'b0);
            check1("clr_b_gnt", bus.b_gnt, 1'b0);
            check1("clr_rvalid", bus.a_rvalid | bus.b_rvalid, 1'b0);
            refmem[m_idx] = '0;
            m_idx++;
            if (m_idx == D) begin m_clear = 1'b0; m_idx = 0; end
        end else begin
            if (pipe.size() > 0) begin
                acc = pipe.pop_front();
                if (acc.we) begin
                    ewe = 1;
                    check("run_wr_addr", 32'(bus.mem_wr_addr), 32'(acc.addr));
                    check("run_wr_din", bus.mem_wr_din, acc.data);
                    refmem[acc.addr] = acc.data;
                end else begin
                    check("run_rd_addr", 32'(bus.mem_rd_addr), 32'(acc.addr));
                    erd = refmem[acc.addr];
                    if (acc.id) erb = 1; else era = 1;
                end
            end
            if (bus.clear_start) begin
                m_clear = 1'b1;
            end else if (bus.a_req && (!bus.b_req || m_last)) begin
                ea = 1; m_last = 1'b0;
                pipe.push_back(mk(1'b0, bus.a_we, bus.a_addr, bus.a_wdata));
            end else if (bus.b_req) begin
                eb = 1; m_last = 1'b1;
                pipe.push_back(mk(1'b1, bus.b_we, bus.b_addr, bus.b_wdata));
            end
            check1("run_busy", bus.clear_busy, 1'b0);
            check1("run_a_gnt", bus.a_gnt, ea);
            check1("run_b_gnt", bus.b_gnt, eb);
            check1("run_a_rvalid", bus.a_rvalid, era);
            check1("run_b_rvalid", bus.b_rvalid, erb);
            check1("run_mem_we", bus.mem_we, ewe);
            check("run_rdata", bus.rdata, erd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic busy_len(output int n);
        n = 0;
        for (int k = 0; k < 100 && bus.clear_busy; k++) begin
            n++;
            @(posedge clk); #1;
            @(negedge clk);
        end
    endtask

    task automatic reset_and_clear(input string name);
        int nb;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        busy_len(nb);
        check(name, 32'(nb), 32'd32);
        @(posedge clk); #1;
    endtask

    task automatic access(input bit is_b, input bit we, input logic [AW-1:0] addr,
                          input logic [W-1:0] d, output logic [W-1:0] rd);
        bit got;
        got = 0;
        rd  = '0;
        if (is_b) begin bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = d; end
        else      begin bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = d; end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (is_b ? bus.b_gnt : bus.a_gnt) begin got = 1; break; end
            @(posedge clk); #1;
        end
        check1("grant_wait", got, 1'b1);
        @(posedge clk); #1;
        if (is_b) bus.b_req = 0; else bus.a_req = 0;
        if (!we) begin
            @(negedge clk);
            check1("owner_rvalid", is_b ? bus.b_rvalid : bus.a_rvalid, 1'b1);
            rd = bus.rdata;
            @(posedge clk); #1;
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end

    initial begin : driver
        logic [W-1:0] rd;
        logic [5:0]   order;
        int           nb, ngr;
        bit           ag, bg, found;

        bus.clear_start = 0;
        bus.a_req = 0; bus.b_req = 0; bus.a_we = 0; bus.b_we = 0;
        bus.a_addr = '0; bus.b_addr = '0; bus.a_wdata = '0; bus.b_wdata = '0;
        bus0.clear_start = 0;
        bus0.a_req = 1; bus0.b_req = 0; bus0.a_we = 0; bus0.b_we = 0;
        bus0.a_addr = '0; bus0.b_addr = '0; bus0.a_wdata = '0; bus0.b_wdata = '0;
        rst = 1; garble = 1;
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        check1("dut0_gnt_in_rst", bus0.a_gnt, 1'b0);
        @(posedge clk); #1;
        rst = 0; garble = 0;

        // CLEAR_ON_RESET=0 instance grants immediately; this instance clears.
        @(negedge clk);
        check1("dut0_first_gnt", bus0.a_gnt, 1'b1);
        check1("dut0_busy", bus0.clear_busy, 1'b0);
        check1("dut0_mem_we", bus0.mem_we, 1'b0);
        busy_len(nb);
        check("reset_clear_len", 32'(nb), 32'd32);
        @(posedge clk); #1;

        access(1'b0, 1'b0, 5'd5, '0, rd);
        check("read5_after_clear", rd, 32'd0);

        access(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, rd);
        access(1'b0, 1'b0, 5'd3, '0, rd);
        check("raw_addr3", rd, 32'hDEADBEEF);

        reset_and_clear("contention_clear_len");
        bus.a_we = 0; bus.b_we = 0; bus.a_addr = 5'd1; bus.b_addr = 5'd2;
        bus.a_req = 1; bus.b_req = 1;
        order = '0; ngr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            order = {order[4:0], bus.b_gnt};
            ngr += int'(bus.a_gnt) + int'(bus.b_gnt);
            @(posedge clk); #1;
        end
        bus.a_req = 0; bus.b_req = 0;
        check("contention_order", 32'(order), 32'b010101);
        check("contention_grants", 32'(ngr), 32'd6);

        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd7; bus.b_wdata = 32'h55;
        bus.clear_start = 1;
        @(negedge clk);
        check1("cs_b_held", bus.b_gnt, 1'b0);
        @(posedge clk); #1;
        bus.clear_start = 0;
        @(negedge clk);
        busy_len(nb);
        check("cs_clear_len", 32'(nb), 32'd32);
        check1("cs_b_gnt_after", bus.b_gnt, 1'b1);
        @(posedge clk); #1;
        bus.b_req = 0;
        access(1'b0, 1'b0, 5'd7, '0, rd);
        check("cs_readback7", rd, 32'h55);

        bus.clear_start = 1;
        @(posedge clk); #1;
        bus.clear_start = 0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.clear_busy && bus.mem_wr_addr == 5'd9) begin found = 1; break; end
            @(posedge clk); #1;
        end
        check1("reach_cnt9", found, 1'b1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check1("rst_mid_clear_we", bus.mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("restart_addr", 32'(bus.mem_wr_addr), 32'd0);
        busy_len(nb);
        check("restart_len", 32'(nb), 32'd32);
        @(posedge clk); #1;

        ag = 0; bg = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            bus.clear_start = ($urandom_range(79) == 0);
            if (!bus.a_req || ag) begin
                bus.a_req = 1'($urandom_range(1)); bus.a_we = 1'($urandom_range(1));
                bus.a_addr = AW'($urandom_range(15)); bus.a_wdata = $urandom;
            end
            if (!bus.b_req || bg) begin
                bus.b_req = 1'($urandom_range(1)); bus.b_we = 1'($urandom_range(1));
                bus.b_addr = AW'($urandom_range(15)); bus.b_wdata = $urandom;
            end
            @(negedge clk);
            ag = bus.a_gnt; bg = bus.b_gnt;
            @(posedge clk); #1;
        end
        rst = 0; bus.clear_start = 0; bus.a_req = 0; bus.b_req = 0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
